// File: rtl/lcd_hd44780_rx.sv
// HD44780 4-bit bus receiver: samples RS/D7..D4 on falling E, rebuilds bytes, decodes instructions.
// Optional LCD_RX_DISPBUF_EN adds a 32x8 mirror of DDRAM lines 0x00-0x0F and 0x40-0x4F.
module lcd_hd44780_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RS,
  input  logic              E,
  input  logic              D4,
  input  logic              D5,
  input  logic              D6,
  input  logic              D7,
  output logic              BYTE_VALID,
  output logic [7:0]        BYTE_DATA,
  output logic              BYTE_RS,
  output logic              CHAR_WE,
  output logic [ADDR_W-1:0] CHAR_ADDR,
  output logic [ADDR_W-1:0] CUR_ADDR,
  output logic              MODE4,
  output logic              DISP_ON
`ifdef LCD_RX_DISPBUF_EN
  ,
  input  logic [4:0]        RD_ADDR,
  output logic [7:0]        RD_DATA
`endif
);

  // Bus vector layout: {E, RS, D7, D6, D5, D4}
  logic [5:0] bus_in;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] bus_sync;
  logic [5:0] prev_q;
  logic       fall;
  logic [3:0] nib;

  assign bus_in   = {E, RS, D7, D6, D5, D4};
  assign bus_sync = sync_q[SYNC_STAGES-1];
  assign fall     = prev_q[5] & ~bus_sync[5];
  assign nib      = prev_q[3:0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= bus_sync;
    end
  end

  logic              mode4_q, mode4_d;
  logic              phase_hi_q, phase_hi_d;
  logic [3:0]        hi_nib_q, hi_nib_d;
  logic              id_q, id_d;
  logic              disp_on_q, disp_on_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              byte_valid_q, byte_valid_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_rs_q, byte_rs_d;
  logic              char_we_q, char_we_d;
  logic [ADDR_W-1:0] char_addr_q, char_addr_d;

  logic       done;
  logic [7:0] byte_val;
  logic       byte_rs;

  always_comb begin
    mode4_d      = mode4_q;
    phase_hi_d   = phase_hi_q;
    hi_nib_d     = hi_nib_q;
    id_d         = id_q;
    disp_on_d    = disp_on_q;
    cur_addr_d   = cur_addr_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_rs_d    = byte_rs_q;
    char_we_d    = 1'b0;
    char_addr_d  = char_addr_q;
    done         = 1'b0;
    byte_val     = 8'h00;
    byte_rs      = prev_q[4];

    if (fall) begin
      if (!mode4_q) begin
        done     = 1'b1;
        byte_val = {nib, 4'h0};
      end else if (phase_hi_q) begin
        hi_nib_d   = nib;
        phase_hi_d = 1'b0;
      end else begin
        done       = 1'b1;
        byte_val   = {hi_nib_q, nib};
        phase_hi_d = 1'b1;
      end
    end

    if (done) begin
      byte_valid_d = 1'b1;
      byte_data_d  = byte_val;
      byte_rs_d    = byte_rs;
      if (byte_rs) begin
        char_we_d   = 1'b1;
        char_addr_d = cur_addr_q;
        cur_addr_d  = id_q ? cur_addr_q + ADDR_W'(1) : cur_addr_q - ADDR_W'(1);
      end else begin
        // Instruction class is given by the highest set bit
        casez (byte_val)
          8'b1???????: cur_addr_d = ADDR_W'(byte_val[6:0]);
          8'b01??????: ;
          8'b001?????: begin
            mode4_d = ~byte_val[4];
            if (mode4_d != mode4_q) phase_hi_d = 1'b1;
          end
          8'b0001????: ;
          8'b00001???: disp_on_d = byte_val[2];
          8'b000001??: id_d = byte_val[1];
          8'b0000001?: cur_addr_d = '0;
          8'b00000001: begin
            cur_addr_d = '0;
            id_d       = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode4_q      <= 1'b0;
      phase_hi_q   <= 1'b1;
      hi_nib_q     <= 4'h0;
      id_q         <= 1'b1;
      disp_on_q    <= 1'b0;
      cur_addr_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_rs_q    <= 1'b0;
      char_we_q    <= 1'b0;
      char_addr_q  <= '0;
    end else begin
      mode4_q      <= mode4_d;
      phase_hi_q   <= phase_hi_d;
      hi_nib_q     <= hi_nib_d;
      id_q         <= id_d;
      disp_on_q    <= disp_on_d;
      cur_addr_q   <= cur_addr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_rs_q    <= byte_rs_d;
      char_we_q    <= char_we_d;
      char_addr_q  <= char_addr_d;
    end
  end

  assign BYTE_VALID = byte_valid_q;
  assign BYTE_DATA  = byte_data_q;
  assign BYTE_RS    = byte_rs_q;
  assign CHAR_WE    = char_we_q;
  assign CHAR_ADDR  = char_addr_q;
  assign CUR_ADDR   = cur_addr_q;
  assign MODE4      = mode4_q;
  assign DISP_ON    = disp_on_q;

`ifdef LCD_RX_DISPBUF_EN
  logic [7:0]  buf_q [32];
  logic        buf_hit;
  logic [4:0]  buf_idx;
  logic        buf_clr;
  logic [31:0] addr_ext;

  assign addr_ext = 32'(cur_addr_q);
  assign buf_clr  = done && !byte_rs && (byte_val == 8'h01);

  // Line 1 (0x00-0x0F) maps to entries 0-15, line 2 (0x40-0x4F) to 16-31
  always_comb begin
    buf_hit = 1'b0;
    buf_idx = 5'd0;
    if (addr_ext < 32'd16) begin
      buf_hit = 1'b1;
      buf_idx = addr_ext[4:0];
    end else if (addr_ext >= 32'h40 && addr_ext < 32'h50) begin
      buf_hit = 1'b1;
      buf_idx = {1'b1, addr_ext[3:0]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (buf_clr) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (char_we_d && buf_hit) begin
      buf_q[buf_idx] <= byte_val;
    end
  end

  assign RD_DATA = buf_q[RD_ADDR];
`endif

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Directed bench for lcd_hd44780_rx: table of bus transfers plus reset and display-buffer sequences.
module tb_lcd_hd44780_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rs = 1'b0;
  logic       e = 1'b0;
  logic [3:0] d = 4'h0;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic       char_we;
  logic [6:0] char_addr;
  logic [6:0] cur_addr;
  logic       mode4;
  logic       disp_on;
`ifdef LCD_RX_DISPBUF_EN
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
`endif

  lcd_hd44780_rx #(
    .SYNC_STAGES(2),
    .ADDR_W(7)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .RS(rs),
    .E(e),
    .D4(d[0]),
    .D5(d[1]),
    .D6(d[2]),
    .D7(d[3]),
    .BYTE_VALID(byte_valid),
    .BYTE_DATA(byte_data),
    .BYTE_RS(byte_rs),
    .CHAR_WE(char_we),
    .CHAR_ADDR(char_addr),
    .CUR_ADDR(cur_addr),
    .MODE4(mode4),
    .DISP_ON(disp_on)
`ifdef LCD_RX_DISPBUF_EN
    ,
    .RD_ADDR(rd_addr),
    .RD_DATA(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Pulse monitor: counts BYTE_VALID pulses and captures what came with them
  int         pulses = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_rs = 1'b0;
  logic       cap_we = 1'b0;
  logic [6:0] cap_char = 7'h00;
  always @(negedge clk) begin
    if (byte_valid) begin
      pulses++;
      cap_data = byte_data;
      cap_rs   = byte_rs;
      cap_we   = char_we;
      cap_char = char_addr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_nib(input logic r, input logic [3:0] n);
    @(negedge clk);
    rs = r;
    d  = n;
    e  = 1'b1;
    repeat (4) @(negedge clk);
    e = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b);
    send_nib(r, b[7:4]);
    send_nib(r, b[3:0]);
  endtask

  typedef struct {
    logic       four;
    logic       rs;
    logic [7:0] val;
    logic [6:0] exp_char;
    logic [6:0] exp_cur;
    logic       exp_mode4;
    logic       exp_disp;
  } vec_t;

  vec_t vecs [21];

  initial begin
    int p0;
    vecs[0]  = '{1'b0, 1'b0, 8'h30, 7'h00, 7'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h30, 7'h00, 7'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h30, 7'h00, 7'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h20, 7'h00, 7'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'h54, 7'h00, 7'h01, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'hC0, 7'h00, 7'h40, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 8'h41, 7'h40, 7'h41, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h0C, 7'h00, 7'h41, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h04, 7'h00, 7'h41, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h80, 7'h00, 7'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h5A, 7'h00, 7'h7F, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 8'h5B, 7'h7F, 7'h7E, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 8'h06, 7'h00, 7'h7E, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 8'h5C, 7'h7E, 7'h7F, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 8'h5D, 7'h7F, 7'h00, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h28, 7'h00, 7'h00, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b1, 8'h61, 7'h00, 7'h01, 1'b1, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 8'h01, 7'h00, 7'h00, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 8'h08, 7'h00, 7'h00, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 1'b1, 8'h62, 7'h00, 7'h01, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 8'h02, 7'h00, 7'h00, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(byte_valid), 32'd0);
    chk("reset_data", 32'(byte_data), 32'h00);
    chk("reset_we", 32'(char_we), 32'd0);
    chk("reset_cur", 32'(cur_addr), 32'h00);
    chk("reset_mode4", 32'(mode4), 32'd0);
    chk("reset_disp", 32'(disp_on), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      p0 = pulses;
      if (vecs[i].four) send_byte(vecs[i].rs, vecs[i].val);
      else send_nib(vecs[i].rs, vecs[i].val[7:4]);
      chk($sformatf("v%0d_pulses", i), 32'(pulses - p0), 32'd1);
      chk($sformatf("v%0d_data", i), 32'(cap_data), 32'(vecs[i].val));
      chk($sformatf("v%0d_rs", i), 32'(cap_rs), 32'(vecs[i].rs));
      chk($sformatf("v%0d_we", i), 32'(cap_we), 32'(vecs[i].rs));
      if (vecs[i].rs) chk($sformatf("v%0d_char", i), 32'(cap_char), 32'(vecs[i].exp_char));
      chk($sformatf("v%0d_cur", i), 32'(cur_addr), 32'(vecs[i].exp_cur));
      chk($sformatf("v%0d_mode4", i), 32'(mode4), 32'(vecs[i].exp_mode4));
      chk($sformatf("v%0d_disp", i), 32'(disp_on), 32'(vecs[i].exp_disp));
      chk($sformatf("v%0d_valid_low", i), 32'(byte_valid), 32'd0);
    end

    // High nibble alone produces nothing; reset then drops it and returns to 8-bit mode
    send_byte(1'b1, 8'h41);
    chk("pre_rst_cur", 32'(cur_addr), 32'h01);
    p0 = pulses;
    send_nib(1'b1, 4'h5);
    chk("half_no_pulse", 32'(pulses - p0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_mode4", 32'(mode4), 32'd0);
    chk("rst_cur", 32'(cur_addr), 32'h00);
    chk("rst_data", 32'(byte_data), 32'h00);
    p0 = pulses;
    send_nib(1'b0, 4'h3);
    chk("post_rst_pulses", 32'(pulses - p0), 32'd1);
    chk("post_rst_data", 32'(cap_data), 32'h30);
    chk("post_rst_mode4", 32'(mode4), 32'd0);

`ifdef LCD_RX_DISPBUF_EN
    send_nib(1'b0, 4'h2);
    chk("buf_mode4", 32'(mode4), 32'd1);
    send_byte(1'b1, 8'h48);
    send_byte(1'b1, 8'h49);
    send_byte(1'b0, 8'hC0);
    send_byte(1'b1, 8'h58);
    rd_addr = 5'd0;
    #1 chk("buf_rd0", 32'(rd_data), 32'h48);
    rd_addr = 5'd1;
    #1 chk("buf_rd1", 32'(rd_data), 32'h49);
    rd_addr = 5'd16;
    #1 chk("buf_rd16", 32'(rd_data), 32'h58);
    rd_addr = 5'd2;
    #1 chk("buf_rd2", 32'(rd_data), 32'h20);
    send_byte(1'b0, 8'h01);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1 chk($sformatf("buf_clr%0d", i), 32'(rd_data), 32'h20);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_rx.md
Name: lcd_hd44780_rx

Overview:
Receiver/decoder for the HD44780-style 4-bit LCD bus (RS, E, D4–D7) that our badge designs drive. It acts as the display end: it samples the bus on the falling edge of E, reassembles nibbles into bytes and decodes the instructions that the badge sequencer uses. It also tracks the DDRAM address counter, entry mode and display-on state. It is used as an on-chip loopback checker and as the bench reference model for LCD-driving designs.

Parameters:
SYNC_STAGES, 2, flops in the input synchroniser applied to E, RS and D4–D7 (minimum 2)
ADDR_W, 7, width of the DDRAM address counter

Ports:
CLK  input  1  system clock; all state is on the rising edge
RST  input  1  asynchronous, active-low reset
RS  input  1  register select from the bus (0 = instruction, 1 = data)
E  input  1  enable strobe from the bus; data is latched on its falling edge
D4  input  1  bus data bit 4
D5  input  1  bus data bit 5
D6  input  1  bus data bit 6
D7  input  1  bus data bit 7
BYTE_VALID  output  1  one-cycle pulse when a complete byte has been received
BYTE_DATA  output  8  last received byte; held until the next byte
BYTE_RS  output  1  RS value belonging to BYTE_DATA
CHAR_WE  output  1  one-cycle pulse, coincident with BYTE_VALID, for data writes (RS=1)
CHAR_ADDR  output  ADDR_W  DDRAM address written by the current CHAR_WE (value before auto-inc/dec)
CUR_ADDR  output  ADDR_W  current DDRAM address counter
MODE4  output  1  1 = 4-bit interface mode active
DISP_ON  output  1  display-on bit from the last display-control instruction

Behaviour:
- Reset (RST=0, asynchronous): all synchroniser flops 0, MODE4=0 (8-bit mode), nibble phase = HIGH, BYTE_VALID=0, BYTE_DATA=0x00, BYTE_RS=0, CHAR_WE=0, CHAR_ADDR=0, CUR_ADDR=0, entry increment I/D=1, DISP_ON=0.
- Synchroniser: E, RS and D4–D7 each pass through SYNC_STAGES flops of equal depth.
- Falling-edge detect: e_prev=1 and e_sync=0 in cycle k. RS/D7..D4 are taken from the synced values registered in cycle k-1, while E was still high.
- 8-bit mode (MODE4=0): every falling edge forms a byte = {D7..D4, 4'b0000}.
- 4-bit mode, phase HIGH: store the nibble as byte[7:4] and set phase to LOW. No output.
- 4-bit mode, phase LOW: byte = {stored, D7..D4}; RS is taken from this second nibble; set phase to HIGH.
- Output timing: a completed byte asserts BYTE_VALID in cycle k+1 for exactly one cycle, with BYTE_DATA and BYTE_RS updated in the same cycle.
- Data byte (RS=1):
  - CHAR_WE pulses and CHAR_ADDR = CUR_ADDR.
  - CUR_ADDR then moves by ±1 per I/D, modulo 2^ADDR_W: 0x7F+1 → 0x00, 0x00-1 → 0x7F.
- Instruction byte (RS=0), decoded by its highest set bit:
  - 0x01 clear: CUR_ADDR=0, I/D=1.
  - 0x02–0x03 home: CUR_ADDR=0.
  - 0x04–0x07 entry mode: I/D = bit1.
  - 0x08–0x0F display control: DISP_ON = bit2.
  - 0x10–0x1F cursor/display shift: no state change.
  - 0x20–0x3F function set: MODE4 = ~bit4; phase is forced to HIGH when MODE4 changes.
  - 0x40–0x7F CGRAM address: no state change.
  - 0x80–0xFF: CUR_ADDR = byte[6:0].
- Standard init: nibbles 0x3, 0x3, 0x3, 0x2 in 8-bit mode leave MODE4=1. Each nibble produces a BYTE_VALID (0x30, 0x30, 0x30, 0x20).
- Bus reads are not supported; the bus R/W line is tied low by the driver, and no busy flag is modelled.
- A falling edge in the same cycle as a BYTE_VALID pulse is processed normally; the pipeline accepts one edge per cycle.
- Reset mid-byte discards any stored high nibble and returns to 8-bit mode.
- Glitches on E shorter than the synchroniser resolution are not required to be filtered.

Optional Feature:
- Macro: LCD_RX_DISPBUF_EN.
- When defined:
  - Adds ports RD_ADDR (input, 5) and RD_DATA (output, 8, combinational read) and a 32×8 flop buffer.
  - On CHAR_WE, DDRAM 0x00–0x0F is written to entries 0–15 and 0x40–0x4F to entries 16–31; other addresses are not stored.
  - The clear instruction and reset set all entries to 0x20.
- When undefined: no buffer and no extra ports; the rest of the behaviour is identical.

Test Plan:
- Reset, then nibbles 0x3, 0x3, 0x3, 0x2 with RS=0 → four BYTE_VALID pulses (0x30, 0x30, 0x30, 0x20); MODE4=1.
- In 4-bit mode, RS=1 nibbles 0x5, 0x4 → BYTE_DATA=0x54, BYTE_RS=1, CHAR_WE with CHAR_ADDR=0x00; CUR_ADDR=0x01. BYTE_VALID appears only after the second nibble.
- Instruction 0xC0, then data 0x41 → CUR_ADDR=0x40, then CHAR_ADDR=0x40 and CUR_ADDR=0x41. Instruction 0x0C → DISP_ON=1.
- Entry mode 0x04, set address 0x80, data write → CHAR_ADDR=0x00, CUR_ADDR wraps to 0x7F.
- Send high nibble 0x5 only, assert RST low for 1 cycle → MODE4=0, CUR_ADDR=0. The next single nibble 0x3 gives BYTE_VALID with 0x30 immediately.
- With LCD_RX_DISPBUF_EN: write "HI" at 0x00 and 'X' at 0x40 → RD_ADDR 0/1/16 read 0x48/0x49/0x58. After instruction 0x01, all entries read 0x20.
